// File: rtl/hazard_scoreboard_pkg.sv
// rtl/hazard_scoreboard_pkg.sv - shared encodings and default sizes for the hazard scoreboard
package hazard_scoreboard_pkg;

    localparam int DEF_NREG = 32;
    localparam int DEF_AW   = 5;
    localparam int DEF_CW   = 6;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_M  = 2'b10;
    localparam logic [1:0] FWD_W  = 2'b01;

endpackage

// File: rtl/hazard_scoreboard_mc_scoreboard.sv
// rtl/hazard_scoreboard_mc_scoreboard.sv - pending bits, latency counter and completion pulse
module mc_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW,
    parameter int CW   = DEF_CW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue,
    input  logic [AW-1:0]   issueRd,
    input  logic            issueFp,
    input  logic [CW-1:0]   issueLat,
    output logic [NREG-1:0] pendInt,
    output logic [NREG-1:0] pendFp,
    output logic [CW-1:0]   busyCnt,
    output logic            mcWb,
    output logic [AW-1:0]   mcRd,
    output logic            mcFp
);

    logic [NREG-1:0] pendIntNext;
    logic [NREG-1:0] pendFpNext;
    logic [CW-1:0]   issueLatEff;

    // Completion is the last counted cycle of the in-flight op.
    assign mcWb        = (busyCnt == CW'(1));
    assign issueLatEff = (issueLat == '0) ? CW'(1) : issueLat;

    // Clear the completing destination first, then apply the new issue so it wins on the same register.
    always_comb begin
        pendIntNext = pendInt;
        pendFpNext  = pendFp;
        if (mcWb) begin
            if (mcFp) pendFpNext[mcRd]  = 1'b0;
            else      pendIntNext[mcRd] = 1'b0;
        end
        if (issue) begin
            if (issueFp)              pendFpNext[issueRd]  = 1'b1;
            else if (issueRd != '0)   pendIntNext[issueRd] = 1'b1;
        end
    end

    // Scoreboard state; reset discards any in-flight op without a completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendInt <= '0;
            pendFp  <= '0;
            busyCnt <= '0;
            mcRd    <= '0;
            mcFp    <= 1'b0;
        end else begin
            pendInt <= pendIntNext;
            pendFp  <= pendFpNext;
            if (issue)              busyCnt <= issueLatEff;
            else if (busyCnt != '0) busyCnt <= busyCnt - CW'(1);
            if (issue) begin
                mcRd <= issueRd;
                mcFp <= issueFp;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - forwarding, load-use/RAW/WAW/structural stalls and branch flush
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int AW   = DEF_AW,
    parameter int CW   = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_d,
    input  logic [AW-1:0] rs1_d,
    input  logic [AW-1:0] rs2_d,
    input  logic          rs1fp_d,
    input  logic          rs2fp_d,
    input  logic [AW-1:0] rd_d,
    input  logic          rdfp_d,
    input  logic          wr_d,
    input  logic          mc_d,
    input  logic [CW-1:0] mclat_d,
    input  logic [AW-1:0] rs1_e,
    input  logic [AW-1:0] rs2_e,
    input  logic          rs1fp_e,
    input  logic          rs2fp_e,
    input  logic [AW-1:0] rd_e,
    input  logic          rdfp_e,
    input  logic          wr_e,
    input  logic          load_e,
    input  logic          pcsrc_e,
    input  logic [AW-1:0] rd_m,
    input  logic          rdfp_m,
    input  logic          wr_m,
    input  logic [AW-1:0] rd_w,
    input  logic          rdfp_w,
    input  logic          wr_w,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          stall_f,
    output logic          stall_d,
    output logic          flush_d,
    output logic          flush_e,
    output logic          mc_wb,
    output logic [AW-1:0] mc_rd,
    output logic          mc_fp,
    output logic          mc_busy
);

    logic [NREG-1:0] pendInt;
    logic [NREG-1:0] pendFp;
    logic [CW-1:0]   busyCnt;
    logic            loadUse, rawHz, wawHz, structHz, hz, issueMc;
    logic            pendRs1, pendRs2, pendRd, wbSameRd;

    // x0 is hardwired zero and never produces a match; f0 is an ordinary register.
    function automatic logic srcMatch(input logic en, input logic [AW-1:0] dst, input logic dstFp,
                                      input logic [AW-1:0] src, input logic srcFp);
        return en && (dst == src) && (dstFp == srcFp) && ((src != '0) || srcFp);
    endfunction

    // Forward select: the younger M-stage result takes priority over W.
    always_comb begin
        fwd_a_e = FWD_RF;
        fwd_b_e = FWD_RF;
        if (srcMatch(wr_m, rd_m, rdfp_m, rs1_e, rs1fp_e))      fwd_a_e = FWD_M;
        else if (srcMatch(wr_w, rd_w, rdfp_w, rs1_e, rs1fp_e)) fwd_a_e = FWD_W;
        if (srcMatch(wr_m, rd_m, rdfp_m, rs2_e, rs2fp_e))      fwd_b_e = FWD_M;
        else if (srcMatch(wr_w, rd_w, rdfp_w, rs2_e, rs2fp_e)) fwd_b_e = FWD_W;
    end

    assign pendRs1  = rs1fp_d ? pendFp[rs1_d] : pendInt[rs1_d];
    assign pendRs2  = rs2fp_d ? pendFp[rs2_d] : pendInt[rs2_d];
    assign pendRd   = rdfp_d  ? pendFp[rd_d]  : pendInt[rd_d];
    // A destination completing this cycle is retired before a new writer to it can land.
    assign wbSameRd = mc_wb && (mc_rd == rd_d) && (mc_fp == rdfp_d);

    // Hazard detection and pipeline control; a taken branch overrides every stall.
    always_comb begin
        loadUse  = issue_d && load_e &&
                   (srcMatch(wr_e, rd_e, rdfp_e, rs1_d, rs1fp_d) ||
                    srcMatch(wr_e, rd_e, rdfp_e, rs2_d, rs2fp_d));
        rawHz    = issue_d && (pendRs1 || pendRs2);
        wawHz    = issue_d && wr_d && pendRd && !wbSameRd;
        structHz = issue_d && mc_d && (busyCnt > CW'(1));
        hz       = loadUse || rawHz || wawHz || structHz;
        stall_f  = pcsrc_e ? 1'b0 : hz;
        stall_d  = pcsrc_e ? 1'b0 : hz;
        flush_d  = pcsrc_e;
        flush_e  = pcsrc_e ? 1'b1 : hz;
        issueMc  = issue_d && !stall_d && !pcsrc_e && mc_d && wr_d;
    end

    mc_scoreboard #(.NREG(NREG), .AW(AW), .CW(CW)) u_mc (
        .clk      (clk),
        .rst      (rst),
        .issue    (issueMc),
        .issueRd  (rd_d),
        .issueFp  (rdfp_d),
        .issueLat (mclat_d),
        .pendInt  (pendInt),
        .pendFp   (pendFp),
        .busyCnt  (busyCnt),
        .mcWb     (mc_wb),
        .mcRd     (mc_rd),
        .mcFp     (mc_fp)
    );

    assign mc_busy = (busyCnt != '0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_d, rs1fp_d, rs2fp_d, rdfp_d, wr_d, mc_d;
    logic [4:0] rs1_d, rs2_d, rd_d;
    logic [5:0] mclat_d;
    logic [4:0] rs1_e, rs2_e, rd_e;
    logic       rs1fp_e, rs2fp_e, rdfp_e, wr_e, load_e, pcsrc_e;
    logic [4:0] rd_m, rd_w;
    logic       rdfp_m, wr_m, rdfp_w, wr_w;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       stall_f, stall_d, flush_d, flush_e, mc_wb, mc_fp, mc_busy;
    logic [4:0] mc_rd;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .issue_d(issue_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rs1fp_d(rs1fp_d), .rs2fp_d(rs2fp_d), .rd_d(rd_d), .rdfp_d(rdfp_d), .wr_d(wr_d),
        .mc_d(mc_d), .mclat_d(mclat_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rs1fp_e(rs1fp_e),
        .rs2fp_e(rs2fp_e), .rd_e(rd_e), .rdfp_e(rdfp_e), .wr_e(wr_e), .load_e(load_e),
        .pcsrc_e(pcsrc_e), .rd_m(rd_m), .rdfp_m(rdfp_m), .wr_m(wr_m), .rd_w(rd_w),
        .rdfp_w(rdfp_w), .wr_w(wr_w), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .mc_wb(mc_wb), .mc_rd(mc_rd), .mc_fp(mc_fp), .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearIn();
        issue_d = 0; rs1_d = 0; rs2_d = 0; rs1fp_d = 0; rs2fp_d = 0; rd_d = 0; rdfp_d = 0;
        wr_d = 0; mc_d = 0; mclat_d = 0; rs1_e = 0; rs2_e = 0; rs1fp_e = 0; rs2fp_e = 0;
        rd_e = 0; rdfp_e = 0; wr_e = 0; load_e = 0; pcsrc_e = 0; rd_m = 0; rdfp_m = 0;
        wr_m = 0; rd_w = 0; rdfp_w = 0; wr_w = 0;
    endtask

    task automatic mcIssue(input logic [4:0] rd, input logic fp, input logic [5:0] lat);
        clearIn();
        issue_d = 1; mc_d = 1; wr_d = 1; rd_d = rd; rdfp_d = fp; mclat_d = lat;
    endtask

    task automatic readFp3();
        clearIn();
        issue_d = 1; rs1_d = 3; rs1fp_d = 1; rd_d = 4; rdfp_d = 1; wr_d = 1;
    endtask

    initial begin
        clearIn();
        rst = 0;
        #2;
        check("rst_busy", mc_busy, 0);
        check("rst_wb", mc_wb, 0);
        check("rst_rd", mc_rd, 0);
        check("rst_fp", mc_fp, 0);
        check("rst_stall", stall_d, 0);
        issue_d = 1; load_e = 1; wr_e = 1; rd_e = 7; rs2_d = 7; #1;
        check("rst_loaduse", stall_d, 1);
        clearIn();
        tick(); tick();
        rst = 1;
        tick();

        rd_m = 5; wr_m = 1; rd_w = 5; wr_w = 1; rs1_e = 5; #1;
        check("fwd_m_prio", fwd_a_e, 2'b10);
        wr_m = 0; #1;
        check("fwd_w", fwd_a_e, 2'b01);
        rs1_e = 0; rd_m = 0; rd_w = 0; wr_m = 1; #1;
        check("fwd_x0", fwd_a_e, 2'b00);
        rs2_e = 0; rs2fp_e = 1; rdfp_m = 1; #1;
        check("fwd_f0", fwd_b_e, 2'b10);
        clearIn(); rs1_e = 5; rs1fp_e = 1; rd_m = 5; wr_m = 1; #1;
        check("fwd_filediff", fwd_a_e, 2'b00);

        clearIn(); issue_d = 1; load_e = 1; wr_e = 1; rd_e = 7; rs2_d = 7; #1;
        check("lu_stall_f", stall_f, 1);
        check("lu_stall_d", stall_d, 1);
        check("lu_flush_e", flush_e, 1);
        check("lu_flush_d", flush_d, 0);
        tick();
        load_e = 0; wr_e = 0; #1;
        check("lu_release", stall_d, 0);
        load_e = 1; wr_e = 1; rdfp_e = 1; #1;
        check("lu_fp_vs_int", stall_d, 0);

        mcIssue(3, 1, 4); #1;
        check("fdiv_accept", stall_d, 0);
        check("fdiv_idle", mc_busy, 0);
        tick();
        readFp3();
        for (int i = 1; i <= 4; i++) begin
            #1;
            check("fdiv_busy", mc_busy, 1);
            check("fdiv_wb", mc_wb, (i == 4));
            check("fadd_stall", stall_d, 1);
            if (i == 4) begin
                check("fdiv_rd", mc_rd, 3);
                check("fdiv_fp", mc_fp, 1);
            end
            tick();
        end
        #1;
        check("fdiv_done", mc_busy, 0);
        check("fadd_go", stall_d, 0);

        mcIssue(3, 1, 3);
        tick();
        mcIssue(3, 1, 2); #1;
        check("fsqrt_cnt3", stall_d, 1);
        tick(); #1;
        check("fsqrt_cnt2", stall_d, 1);
        tick(); #1;
        check("fsqrt_cnt1_wb", mc_wb, 1);
        check("fsqrt_cnt1_go", stall_d, 0);
        tick();
        readFp3(); wr_d = 0; #1;
        check("fsqrt_busy", mc_busy, 1);
        check("fsqrt_nowb", mc_wb, 0);
        check("fsqrt_pend", stall_d, 1);
        tick(); #1;
        check("fsqrt_wb", mc_wb, 1);
        check("fsqrt_wb_rd", mc_rd, 3);
        tick(); #1;
        check("fsqrt_clear", stall_d, 0);

        mcIssue(3, 1, 4);
        tick();
        readFp3(); mc_d = 1; rd_d = 9; rdfp_d = 0; mclat_d = 2; #1;
        check("br_pre_stall", stall_d, 1);
        pcsrc_e = 1; #1;
        check("br_stall_f", stall_f, 0);
        check("br_stall_d", stall_d, 0);
        check("br_flush_d", flush_d, 1);
        check("br_flush_e", flush_e, 1);
        tick();
        clearIn(); issue_d = 1; rs1_d = 9; #1;
        check("br_no_pend", stall_d, 0);
        check("br_busy_kept", mc_busy, 1);
        tick();
        readFp3(); #1;
        check("pre_rst_stall", stall_d, 1);
        check("pre_rst_busy", mc_busy, 1);
        rst = 0; #1;
        check("mid_rst_busy", mc_busy, 0);
        check("mid_rst_pend", stall_d, 0);
        for (int i = 0; i < 3; i++) begin
            check("mid_rst_nowb", mc_wb, 0);
            tick();
        end
        rst = 1;
        clearIn();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("post_rst_nowb", mc_wb, 0);
            check("post_rst_idle", mc_busy, 0);
            tick();
        end

        mcIssue(0, 0, 0);
        tick();
        clearIn(); issue_d = 1; rs1_d = 0; #1;
        check("lat0_busy", mc_busy, 1);
        check("lat0_wb", mc_wb, 1);
        check("lat0_rd", mc_rd, 0);
        check("x0_no_pend", stall_d, 0);
        tick(); #1;
        check("lat0_done", mc_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREG, default 32, the number of registers per file (integer and FP).
REQ-002 SHALL have parameter AW, default 5, the register-index width (AW = log2 NREG).
REQ-003 SHALL have parameter CW, default 6, the width of the multi-cycle latency counter.
REQ-004 SHALL have ports, in this order:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- issue_d  in  1  the decode instruction is valid.
- rs1_d, rs2_d  in  AW  decode source indices.
- rs1fp_d, rs2fp_d  in  1  the matching source reads the FP file.
- rd_d  in  AW  decode destination index.
- rdfp_d  in  1  the destination is in the FP file.
- wr_d  in  1  the decode instruction writes rd_d.
- mc_d  in  1  the decode instruction is multi-cycle (fdiv, fsqrt, fmul).
- mclat_d  in  CW  latency of the multi-cycle op.
- rs1_e, rs2_e  in  AW  execute source indices.
- rs1fp_e, rs2fp_e  in  1  execute source file flags.
- rd_e  in  AW  execute destination index.
- rdfp_e, wr_e, load_e  in  1  execute destination file, write enable, and load flag.
- pcsrc_e  in  1  branch taken in execute.
- rd_m, rdfp_m, wr_m  in  AW/1/1  memory-stage destination, file, write enable.
- rd_w, rdfp_w, wr_w  in  AW/1/1  writeback-stage destination, file, write enable.
- fwd_a_e, fwd_b_e  out  2  forward select: 00 = register file, 10 = M stage, 01 = W stage.
- stall_f, stall_d, flush_d, flush_e  out  1  pipeline controls.
- mc_wb  out  1  one-cycle pulse when the multi-cycle op completes.
- mc_rd  out  AW  destination index of the completing op.
- mc_fp  out  1  destination file of the completing op.
- mc_busy  out  1  the multi-cycle unit is occupied.

Function
REQ-005 A source matches a stage when: that stage's wr is 1, the indices are equal, the file flags are equal, and the index is not 0 unless the file flag is FP (x0 is never matched; f0 is matched).
REQ-006 fwd_a_e SHALL be 10 if rs1_e matches M; else 01 if it matches W; else 00. fwd_b_e follows the same rule using rs2_e. Both outputs are combinational.
REQ-007 A load-use hazard exists when issue_d=1, load_e=1, and rs1_d or rs2_d matches the E stage under the REQ-005 rules.
REQ-008 The scoreboard SHALL hold one pending bit per register per file (2*NREG bits).
REQ-009 A RAW hazard exists when issue_d=1 and a source register of the decode instruction is pending.
REQ-010 A WAW hazard exists when issue_d=1, wr_d=1, and rd_d is pending.
REQ-011 A structural hazard exists when issue_d=1, mc_d=1, and busy_cnt>1.
REQ-012 hz = load-use OR RAW OR WAW OR structural. When pcsrc_e=0: stall_f = stall_d = flush_e = hz.
REQ-013 When pcsrc_e=1: flush_d = flush_e = 1 and stall_f = stall_d = 0. The branch overrides every stall.
REQ-014 Issue occurs when issue_d=1, stall_d=0, pcsrc_e=0, mc_d=1, and wr_d=1. On issue:
- busy_cnt loads max(mclat_d, 1);
- the registered rd_d and rdfp_d are stored;
- pending[rdfp_d][rd_d] is set, except integer index 0.
REQ-015 busy_cnt SHALL decrement each cycle while it is nonzero. mc_busy = (busy_cnt != 0).
REQ-016 In the cycle busy_cnt==1: mc_wb=1, mc_rd/mc_fp carry the stored destination, and that pending bit clears at the next edge.
REQ-017 Completion and a new issue may occur in the same cycle. The clear is applied first, then the set, so the set wins on the same register.
REQ-018 Single-cycle instructions SHALL never set pending bits.
REQ-019 mclat_d=0 SHALL be treated as latency 1.

Reset
REQ-020 While rst=0, independent of clk:
- all pending bits, busy_cnt, and the stored destination SHALL be 0;
- mc_wb, mc_busy, mc_rd, and mc_fp SHALL be 0.
REQ-021 On reset assertion mid-operation, the in-flight multi-cycle op SHALL be discarded and no mc_wb pulse produced.
REQ-022 Combinational outputs follow their inputs during reset. Since the scoreboard is clear, stalls arise only from load-use.

Structure
REQ-023 A shared package SHALL hold the forward-select encodings (FWD_RF, FWD_M, FWD_W) and the default NREG, AW, CW.
REQ-024 The block SHALL contain one sub-module, mc_scoreboard: pending bits, latency counter, completion pulse. Forwarding and stall logic are combinational in the top.

Verification
REQ-025 rd_m=x5 with wr_m=1, rd_w=x5 with wr_w=1, rs1_e=x5 -> fwd_a_e=10. Same case with wr_m=0 -> fwd_a_e=01. rs1_e=x0 -> 00.
REQ-026 load_e=1 with rd_e=x7; decode rs2_d=x7 -> stall_f=stall_d=flush_e=1 for one cycle. FP load f7 with integer x7 source -> no stall.
REQ-027 Issue fdiv to f3 with mclat_d=4:
- mc_busy is high for 4 cycles;
- an fadd reading f3 stalls until mc_wb (cycle 4, mc_rd=3, mc_fp=1);
- the fadd issues the next cycle.
REQ-028 fsqrt issued at busy_cnt=3 -> stalled; issued at busy_cnt=1 -> accepted same cycle as mc_wb. The new pending bit for the same register remains set.
REQ-029 pcsrc_e=1 while a RAW stall is active -> stall_f=0, flush_d=flush_e=1, and an mc_d instruction in decode does not set pending.
REQ-030 rst deasserted-then-asserted with busy_cnt=2 -> pending and mc_busy clear immediately, and no mc_wb pulse occurs.
